bch_chien_search: RTL and testbench

BCH_CHIEN_SEARCH -- requirements
Module: bch_chien_search

---
 rtl/bch_pkg.sv | 41 ++++
 rtl/bch_chien_search_if.sv | 22 ++
 rtl/bch_gf_mulconst.sv | 17 +
 rtl/bch_chien_search.sv | 142 ++++++++++++++
 tb/tb_bch_chien_search.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bch_pkg.sv
// Field constants and GF(2^m) arithmetic helpers shared by the Chien search blocks.
package bch_pkg;

    localparam int GF_M         = 5;
    localparam int GF_N         = (1 << GF_M) - 1;
    localparam int GF_PRIM_POLY = 37;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } chien_state_e;

    // Shift-and-add product reduced by poly (poly carries the x^m term), m <= 30.
    function automatic logic [31:0] gf_mul(input logic [31:0] a, input logic [31:0] b,
                                           input int m, input logic [31:0] poly);
        logic [31:0] acc;
        logic [31:0] sh;
        acc = '0;
        sh  = a;
        for (int i = 0; i < 31; i++) begin
            if (i < m && b[i]) acc = acc ^ sh;
            sh = sh << 1;
            if (sh[m]) sh = sh ^ poly;
        end
        return acc;
    endfunction

    function automatic logic [31:0] gf_alpha_pow(input int p, input int m, input logic [31:0] poly);
        logic [31:0] r;
        r = 32'd1;
        for (int i = 0; i < p; i++) r = gf_mul(r, 32'd2, m, poly);
        return r;
    endfunction

    function automatic logic [31:0] gf_mul_const(input logic [31:0] a, input int p,
                                                 input int m, input logic [31:0] poly);
        return gf_mul(a, gf_alpha_pow(p, m, poly), m, poly);
    endfunction

endpackage

// File: rtl/bch_chien_search_if.sv
// Polynomial-in / error-location-out bundle of the Chien search block.
interface bch_chien_search_if #(
    parameter int M     = 5,
    parameter int T     = 4,
    parameter int IDX_W = 5,
    parameter int CNT_W = 3
);
    logic [M*(T+1)-1:0] polys;
    logic               polys_v;
    logic               busy;
    logic               loc_v;
    logic [IDX_W-1:0]   loc_idx;
    logic               loc_err;
    logic               done;
    logic [CNT_W-1:0]   err_cnt;
    logic               fail;

    modport master (output polys, polys_v,
                    input  busy, loc_v, loc_idx, loc_err, done, err_cnt, fail);
    modport slave  (input  polys, polys_v,
                    output busy, loc_v, loc_idx, loc_err, done, err_cnt, fail);
endinterface

// File: rtl/bch_gf_mulconst.sv
// Multiply a GF(2^m) element by the constant alpha^P_POW (pure XOR network).
module bch_gf_mulconst
    import bch_pkg::*;
#(
    parameter int          P_POW  = 1,
    parameter int          P_M    = GF_M,
    parameter logic [31:0] P_POLY = GF_PRIM_POLY
) (
    input  logic [P_M-1:0] a_i,
    output logic [P_M-1:0] y_o
);

    localparam logic [31:0] ALPHA_P = gf_alpha_pow(P_POW, P_M, P_POLY);

    assign y_o = P_M'(gf_mul(32'(a_i), ALPHA_P, P_M, P_POLY));

endmodule

// File: rtl/bch_chien_search.sv
// Chien search: evaluates Lambda(alpha^k) for k = 0..n-1, one position per cycle.
module bch_chien_search
    import bch_pkg::*;
#(
    parameter int C_INDWIDTH  = GF_M,
    parameter int C_ERR_NUM   = 4,
    parameter int C_PRIM_POLY = GF_PRIM_POLY,
    parameter int C_CODE_LEN  = 2**C_INDWIDTH - 1
) (
    input  logic                                I_clk,
    input  logic                                I_rst,
    input  logic [C_INDWIDTH*(C_ERR_NUM+1)-1:0] I_error_loc_polys,
    input  logic                                I_error_loc_polys_v,
    output logic                                O_busy,
    output logic                                O_loc_v,
    output logic [$clog2(C_CODE_LEN)-1:0]       O_loc_idx,
    output logic                                O_loc_err,
    output logic                                O_done,
    output logic [$clog2(C_ERR_NUM+1)-1:0]      O_err_cnt,
    output logic                                O_fail
);

    localparam int IDX_W = $clog2(C_CODE_LEN);
    localparam int CNT_W = $clog2(C_ERR_NUM + 1);
    localparam int K_W   = $clog2(C_CODE_LEN + 1);
    localparam logic [K_W-1:0]   K_LAST  = K_W'(C_CODE_LEN);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(C_ERR_NUM);

    typedef logic [C_INDWIDTH-1:0] sym_t;

    chien_state_e          state_q;
    sym_t [C_ERR_NUM:0]    lam_q;
    sym_t [C_ERR_NUM:0]    lam_d;
    logic [K_W-1:0]        k_q;
    logic [CNT_W-1:0]      deg_q;
    logic [CNT_W-1:0]      root_cnt_q;
    logic                  busy_q;
    logic                  loc_v_q;
    logic [IDX_W-1:0]      idx_q;
    logic                  loc_err_q;
    logic                  done_q;
    logic [CNT_W-1:0]      err_cnt_q;
    logic                  fail_q;

    sym_t                  eval_d;
    logic                  root_d;
    logic [IDX_W-1:0]      idx_d;
    logic [CNT_W-1:0]      deg_d;

    // Register 0 holds the constant term and never changes during a search.
    assign lam_d[0] = lam_q[0];

    for (genvar gi = 1; gi <= C_ERR_NUM; gi++) begin : g_mul
        bch_gf_mulconst #(
            .P_POW  (gi),
            .P_M    (C_INDWIDTH),
            .P_POLY (C_PRIM_POLY)
        ) u_mul (
            .a_i (lam_q[gi]),
            .y_o (lam_d[gi])
        );
    end

    always_comb begin
        eval_d = '0;
        for (int i = 0; i <= C_ERR_NUM; i++) eval_d = eval_d ^ lam_q[i];
        root_d = (eval_d == '0);
        idx_d  = (k_q == '0) ? '0 : IDX_W'(C_CODE_LEN - int'(k_q));
    end

    always_comb begin
        deg_d = '0;
        for (int i = 1; i <= C_ERR_NUM; i++) begin
            if (I_error_loc_polys[C_INDWIDTH*i +: C_INDWIDTH] != '0) deg_d = CNT_W'(i);
        end
    end

    // RUN spends k = 0..n-1 evaluating and one extra cycle (k = n) closing out the verdict.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state_q    <= ST_IDLE;
            lam_q      <= '0;
            k_q        <= '0;
            deg_q      <= '0;
            root_cnt_q <= '0;
            busy_q     <= 1'b0;
            loc_v_q    <= 1'b0;
            idx_q      <= '0;
            loc_err_q  <= 1'b0;
            done_q     <= 1'b0;
            err_cnt_q  <= '0;
            fail_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (I_error_loc_polys_v) begin
                        lam_q      <= I_error_loc_polys;
                        deg_q      <= deg_d;
                        k_q        <= '0;
                        root_cnt_q <= '0;
                        busy_q     <= 1'b1;
                        err_cnt_q  <= '0;
                        fail_q     <= 1'b0;
                        state_q    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (k_q == K_LAST) begin
                        loc_v_q   <= 1'b0;
                        loc_err_q <= 1'b0;
                        done_q    <= 1'b1;
                        err_cnt_q <= root_cnt_q;
                        fail_q    <= (lam_q[0] == '0) || (root_cnt_q != deg_q);
                        state_q   <= ST_DONE;
                    end else begin
                        lam_q     <= lam_d;
                        k_q       <= k_q + K_W'(1);
                        loc_v_q   <= 1'b1;
                        loc_err_q <= root_d;
                        idx_q     <= idx_d;
                        if (root_d && root_cnt_q != CNT_MAX) root_cnt_q <= root_cnt_q + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign O_busy    = busy_q;
    assign O_loc_v   = loc_v_q;
    assign O_loc_idx = idx_q;
    assign O_loc_err = loc_err_q;
    assign O_done    = done_q;
    assign O_err_cnt = err_cnt_q;
    assign O_fail    = fail_q;

endmodule

// File: tb/tb_bch_chien_search.sv
// Bench for bch_chien_search over GF(32): vector table plus hand-written corner sequences.
module tb_bch_chien_search;

    localparam int M  = 5;
    localparam int T  = 4;
    localparam int N  = 31;
    localparam int IW = 5;
    localparam int CW = 3;

    typedef struct {
        string       name;
        logic [24:0] poly;
        logic [30:0] mask;
        int          cnt;
        int          fail;
    } vec_t;

    typedef struct {
        logic [30:0] mask;
        int          cnt;
        int          fail;
        int          tbad;
        int          sbad;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_bad = 0;
    int   exp_t [0:30];
    int   log_t [0:31];
    vec_t vecs [$];

    always #5 clk = ~clk;

    bch_chien_search_if #(.M(M), .T(T), .IDX_W(IW), .CNT_W(CW)) bus ();

    bch_chien_search #(
        .C_INDWIDTH  (M),
        .C_ERR_NUM   (T),
        .C_PRIM_POLY (37),
        .C_CODE_LEN  (N)
    ) dut (
        .I_clk               (clk),
        .I_rst               (rst),
        .I_error_loc_polys   (bus.polys),
        .I_error_loc_polys_v (bus.polys_v),
        .O_busy              (bus.busy),
        .O_loc_v             (bus.loc_v),
        .O_loc_idx           (bus.loc_idx),
        .O_loc_err           (bus.loc_err),
        .O_done              (bus.done),
        .O_err_cnt           (bus.err_cnt),
        .O_fail              (bus.fail)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference arithmetic through log/antilog tables.
    function automatic int gmul(input int a, input int b);
        if (a == 0 || b == 0) return 0;
        return exp_t[(log_t[a] + log_t[b]) % N];
    endfunction

    function automatic int coef(input logic [24:0] p, input int i);
        return int'((p >> (5 * i)) & 25'h1f);
    endfunction

    function automatic logic [24:0] pk(input int c0, input int c1, input int c2, input int c3, input int c4);
        return 25'(c0) | (25'(c1) << 5) | (25'(c2) << 10) | (25'(c3) << 15) | (25'(c4) << 20);
    endfunction

    function automatic int peval(input logic [24:0] p, input int x);
        int acc;
        acc = 0;
        for (int i = T; i >= 0; i--) acc = gmul(acc, x) ^ coef(p, i);
        return acc;
    endfunction

    // Position j is in error when Lambda(alpha^-j) == 0.
    function automatic vec_t model(input string name, input logic [24:0] p);
        vec_t v;
        int   nr;
        int   deg;
        nr = 0;
        deg = 0;
        v.name = name;
        v.poly = p;
        v.mask = '0;
        for (int j = 0; j < N; j++) begin
            if (peval(p, exp_t[(N - j) % N]) == 0) begin
                v.mask[j] = 1'b1;
                nr++;
            end
        end
        for (int i = 1; i <= T; i++) if (coef(p, i) != 0) deg = i;
        v.cnt  = (nr > T) ? T : nr;
        v.fail = (coef(p, 0) == 0 || nr != deg) ? 1 : 0;
        return v;
    endfunction

    function automatic vec_t from_roots(input string name, input int nroots);
        vec_t v;
        int   c [5];
        int   got;
        int   j;
        c = '{1, 0, 0, 0, 0};
        got = 0;
        v.mask = '0;
        while (got < nroots) begin
            j = $urandom_range(0, N - 1);
            if (!v.mask[j]) begin
                v.mask[j] = 1'b1;
                for (int i = T; i >= 1; i--) c[i] = c[i] ^ gmul(exp_t[j], c[i-1]);
                got++;
            end
        end
        v.name = name;
        v.poly = pk(c[0], c[1], c[2], c[3], c[4]);
        v.cnt  = nroots;
        v.fail = 0;
        return v;
    endfunction

    // Cycle T is the negedge-to-posedge window with the strobe high; sample at negedge of T+c.
    task automatic do_search(input logic [24:0] poly, input int intr_c, input logic [24:0] ipoly,
                             input bit chained, output res_t r);
        int idx;
        r.mask = '0;
        r.cnt  = 0;
        r.fail = 0;
        r.tbad = 0;
        r.sbad = 0;
        if (!chained) begin
            @(negedge clk);
            bus.polys   = poly;
            bus.polys_v = 1'b1;
        end
        for (int c = 1; c <= N + 3; c++) begin
            @(negedge clk);
            bus.polys_v = 1'b0;
            if (c == intr_c) begin
                bus.polys   = ipoly;
                bus.polys_v = 1'b1;
            end
            if (bus.busy !== (c <= N + 2) || bus.loc_v !== (c >= 2 && c <= N + 1) ||
                bus.done !== (c == N + 2)) r.tbad++;
            if (bus.loc_v) begin
                idx = int'(bus.loc_idx);
                if (idx != (N - (c - 2)) % N) r.sbad++;
                if (bus.loc_err && idx < N) r.mask[idx] = 1'b1;
            end
            if (c == N + 2) begin
                r.cnt  = int'(bus.err_cnt);
                r.fail = int'(bus.fail);
            end
            if (c == N + 3 && (int'(bus.err_cnt) != r.cnt || int'(bus.fail) != r.fail)) r.tbad++;
        end
    endtask

    task automatic chk_res(input string name, input res_t r, input vec_t v);
        chk({name, "_mask"}, 32'(r.mask), 32'(v.mask));
        chk({name, "_cnt"}, 32'(r.cnt), 32'(v.cnt));
        chk({name, "_fail"}, 32'(r.fail), 32'(v.fail));
        chk({name, "_timing"}, 32'(r.tbad), 32'd0);
        chk({name, "_idxseq"}, 32'(r.sbad), 32'd0);
    endtask

    initial begin
        res_t r;
        vec_t v;
        int   e;
        int   bad;

        e = 1;
        log_t[0] = 0;
        for (int i = 0; i < N; i++) begin
            exp_t[i] = e;
            log_t[e] = i;
            e = e << 1;
            if ((e & 32) != 0) e = e ^ 37;
        end

        rst = 1'b1;
        bus.polys = '0;
        bus.polys_v = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_outputs", 32'({bus.busy, bus.loc_v, bus.loc_err, bus.done, bus.fail,
                                  bus.err_cnt, bus.loc_idx}), 32'd0);

        vecs.push_back('{"single_idx3", pk(1, 8, 0, 0, 0), 31'h8, 1, 0});
        vecs.push_back('{"double_idx0_5", pk(1, 4, 5, 0, 0), 31'h21, 2, 0});
        vecs.push_back('{"no_error", pk(1, 0, 0, 0, 0), 31'h0, 0, 0});
        vecs.push_back('{"uncorrectable", pk(1, 1, 1, 0, 0), 31'h0, 0, 1});
        vecs.push_back('{"lambda0_zero", pk(0, 1, 0, 0, 0), 31'h0, 0, 1});
        vecs.push_back('{"all_zero_sat", pk(0, 0, 0, 0, 0), 31'h7fffffff, 4, 1});
        for (int i = 0; i < 6; i++) vecs.push_back(from_roots($sformatf("roots%0d", i), 1 + i % 4));
        for (int i = 0; i < 6; i++) vecs.push_back(model($sformatf("rand%0d", i), 25'($urandom)));

        foreach (vecs[i]) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            do_search(vecs[i].poly, 0, '0, 1'b0, r);
            chk_res(vecs[i].name, r, vecs[i]);
        end

        // Strobe with a different polynomial mid-RUN must be ignored.
        v = vecs[0];
        do_search(v.poly, 10, pk(1, 4, 5, 0, 0), 1'b0, r);
        chk_res("strobe_in_run", r, v);
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.busy || bus.loc_v) bad++;
        end
        chk("strobe_in_run_no_second", 32'(bad), 32'd0);

        // Strobe on the O_done cycle is still ignored.
        v = vecs[1];
        do_search(v.poly, N + 2, pk(1, 8, 0, 0, 0), 1'b0, r);
        chk_res("strobe_at_done", r, v);
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.busy) bad++;
        end
        chk("strobe_at_done_ignored", 32'(bad), 32'd0);

        // Earliest acceptance at T+n+3, back to back; results then held while idle.
        do_search(vecs[0].poly, N + 3, vecs[1].poly, 1'b0, r);
        chk_res("b2b_first", r, vecs[0]);
        do_search('0, 0, '0, 1'b1, r);
        chk_res("b2b_second", r, vecs[1]);
        repeat (5) @(negedge clk);
        chk("hold_cnt", 32'(bus.err_cnt), 32'd2);

        // Reset at T+15 aborts the search with no O_done.
        @(negedge clk);
        bus.polys   = vecs[0].poly;
        bus.polys_v = 1'b1;
        bad = 0;
        for (int c = 1; c <= N + 3; c++) begin
            @(negedge clk);
            bus.polys_v = 1'b0;
            if (c == 15) begin
                chk("rst_mid_busy_before", 32'(bus.busy), 32'd1);
                rst = 1'b1;
            end
            if (c == 16) begin
                chk("rst_mid_zero", 32'({bus.busy, bus.loc_v, bus.loc_err, bus.done, bus.fail,
                                         bus.err_cnt, bus.loc_idx}), 32'd0);
                rst = 1'b0;
            end
            if (c > 16 && (bus.done || bus.busy)) bad++;
        end
        chk("rst_mid_quiet", 32'(bad), 32'd0);
        do_search(vecs[1].poly, 0, '0, 1'b0, r);
        chk_res("after_rst", r, vecs[1]);

        // Reset wins over a simultaneous strobe.
        @(negedge clk);
        rst = 1'b1;
        bus.polys   = vecs[0].poly;
        bus.polys_v = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.polys_v = 1'b0;
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.busy || bus.loc_v) bad++;
        end
        chk("rst_prio_dropped", 32'(bad), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
